// File: rtl/int_adder_tree_stream.sv
// ----------------------------------------------------------------------------
// int_adder_tree_stream
//
// Fully pipelined integer adder tree. It reduces NUM_IN_WORDS operand words
// to one sum per accepted vector. An optional accumulator then folds
// ACC_BEATS consecutive tree results into a single output. The block uses a
// valid/ready handshake. When the output register holds a sum that
// downstream has not taken, the whole pipeline freezes.
//
// Pipeline: input register (layer 0), then NUM_LAYERS pairwise-sum layers,
// then the accumulator/output register. With no stall, an input accepted at
// edge t shows up on data_out after edge t + NUM_LAYERS + 1.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   data_in        NUM_IN_WORDS words of IN_WIDTH bits, word i at
//                  [i*IN_WIDTH +: IN_WIDTH]
//   data_in_valid  operand vector valid
//   data_in_ready  vector accepted this cycle (combinational from
//                  data_out_ready)
//   data_out       final sum, OUT_WIDTH bits (two's complement if SIGNED)
//   data_out_valid final sum valid
//   data_out_ready downstream accepts the sum
//   beat_count     tree results already folded into the current accumulation
// ----------------------------------------------------------------------------
module int_adder_tree_stream #(
    parameter int NUM_IN_WORDS = 8,
    parameter int IN_WIDTH     = 8,
    parameter int SIGNED       = 1,
    parameter int ACC_BEATS    = 1,
    localparam int NUM_LAYERS  = $clog2(NUM_IN_WORDS),
    localparam int TREE_WIDTH  = IN_WIDTH + NUM_LAYERS,
    localparam int OUT_WIDTH   = TREE_WIDTH + $clog2(ACC_BEATS),
    localparam int BC_WIDTH    = $clog2(ACC_BEATS) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_IN_WORDS*IN_WIDTH-1:0] data_in,
    input  logic                             data_in_valid,
    output logic                             data_in_ready,
    output logic [OUT_WIDTH-1:0]             data_out,
    output logic                             data_out_valid,
    input  logic                             data_out_ready,
    output logic [BC_WIDTH-1:0]              beat_count
);

    logic                  advance;
    logic [OUT_WIDTH-1:0]  data_out_q;
    logic                  data_out_valid_q;
    logic [BC_WIDTH-1:0]   beat_count_q;
    logic [OUT_WIDTH-1:0]  acc_q;

    // The whole pipeline moves together. It only stops when a finished sum
    // is waiting and downstream refuses it.
    assign advance       = !data_out_valid_q || data_out_ready;
    assign data_in_ready = advance;

    // ------------------------------------------------------------------
    // Tree layers. Layer k holds ceil(NUM_IN_WORDS / 2^k) words of
    // IN_WIDTH + k bits.
    // ------------------------------------------------------------------
    for (genvar k = 0; k <= NUM_LAYERS; k++) begin : g_layer
        localparam int CNT = (NUM_IN_WORDS + (1 << k) - 1) >> k;
        localparam int W   = IN_WIDTH + k;

        logic [W-1:0] word_q [CNT];
        logic         valid_q;

        if (k == 0) begin : g_in
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples the values from before the edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                end else if (advance) begin
                    valid_q <= data_in_valid;
                end
            end

            // NOTE: datapath words are not reset. The valid bits alone say
            // whether a word means anything, so skipping reset here saves
            // reset fan-out without changing behaviour.
            always_ff @(posedge clk) begin
                if (advance && data_in_valid) begin
                    for (int i = 0; i < NUM_IN_WORDS; i++) begin
                        word_q[i] <= data_in[i*IN_WIDTH +: IN_WIDTH];
                    end
                end
            end
        end else begin : g_sum
            localparam int PCNT = (NUM_IN_WORDS + (1 << (k - 1)) - 1) >> (k - 1);

            logic [W-1:0] sum_d [CNT];

            for (genvar i = 0; i < CNT; i++) begin : g_word
                logic [W-2:0] op_a;
                logic         msb_a;

                assign op_a  = g_layer[k-1].word_q[2*i];
                assign msb_a = (SIGNED != 0) && op_a[W-2];

                if (2*i + 1 < PCNT) begin : g_pair
                    logic [W-2:0] op_b;
                    logic         msb_b;

                    assign op_b     = g_layer[k-1].word_q[2*i+1];
                    assign msb_b    = (SIGNED != 0) && op_b[W-2];
                    assign sum_d[i] = {msb_a, op_a} + {msb_b, op_b};
                end else begin : g_pass
                    // An odd word with no partner is widened and carried
                    // through this layer unchanged.
                    assign sum_d[i] = {msb_a, op_a};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                end else if (advance) begin
                    valid_q <= g_layer[k-1].valid_q;
                end
            end

            always_ff @(posedge clk) begin
                if (advance && g_layer[k-1].valid_q) begin
                    word_q <= sum_d;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and output register.
    // ------------------------------------------------------------------
    logic [TREE_WIDTH-1:0] tree_out;
    logic                  tree_valid;
    logic [OUT_WIDTH-1:0]  tree_ext;
    logic [OUT_WIDTH-1:0]  acc_base;
    logic [OUT_WIDTH-1:0]  sum_d;
    logic                  last_beat;

    assign tree_out   = g_layer[NUM_LAYERS].word_q[0];
    assign tree_valid = g_layer[NUM_LAYERS].valid_q;

    if (SIGNED != 0) begin : g_ext_s
        assign tree_ext = OUT_WIDTH'($signed(tree_out));
    end else begin : g_ext_u
        assign tree_ext = OUT_WIDTH'(tree_out);
    end

    // The first beat of an accumulation starts from zero rather than from
    // whatever acc_q held before, so acc_q never needs a clear cycle.
    assign acc_base  = (beat_count_q == '0) ? '0 : acc_q;
    assign sum_d     = acc_base + tree_ext;
    assign last_beat = (beat_count_q == BC_WIDTH'(ACC_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            beat_count_q     <= '0;
            acc_q            <= '0;
        end else if (advance) begin
            if (tree_valid && last_beat) begin
                // A new final sum replaces a sum that is draining this same
                // cycle, so valid stays high.
                data_out_q       <= sum_d;
                data_out_valid_q <= 1'b1;
                beat_count_q     <= '0;
            end else begin
                data_out_valid_q <= 1'b0;
                if (tree_valid) begin
                    acc_q        <= sum_d;
                    beat_count_q <= beat_count_q + BC_WIDTH'(1);
                end
            end
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign beat_count     = beat_count_q;

endmodule

// File: tb/tb_int_adder_tree_stream.sv
// ----------------------------------------------------------------------------
// tb_int_adder_tree_stream
//
// The bench drives three configurations of int_adder_tree_stream from one
// clock and reset:
//   A: 8 words, 8 bits, signed,   ACC_BEATS=1
//   B: 5 words, 8 bits, unsigned, ACC_BEATS=1
//   C: 8 words, 8 bits, signed,   ACC_BEATS=4
// Expected sums come from a reference model. The model sums each accepted
// vector with plain integer arithmetic and groups the sums into beats. The
// results go into per-configuration queues, which are compared against every
// output handshake.
// ----------------------------------------------------------------------------
module tb_int_adder_tree_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [63:0] a_data;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [10:0] a_out;
    logic [0:0]  a_bc;

    logic [39:0] b_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [10:0] b_out;
    logic [0:0]  b_bc;

    logic [63:0] c_data;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [12:0] c_out;
    logic [2:0]  c_bc;

    int_adder_tree_stream #(.NUM_IN_WORDS(8), .IN_WIDTH(8), .SIGNED(1), .ACC_BEATS(1)) dut_a (
        .clk(clk), .rst(rst), .data_in(a_data), .data_in_valid(a_in_valid),
        .data_in_ready(a_in_ready), .data_out(a_out), .data_out_valid(a_out_valid),
        .data_out_ready(a_out_ready), .beat_count(a_bc));

    int_adder_tree_stream #(.NUM_IN_WORDS(5), .IN_WIDTH(8), .SIGNED(0), .ACC_BEATS(1)) dut_b (
        .clk(clk), .rst(rst), .data_in(b_data), .data_in_valid(b_in_valid),
        .data_in_ready(b_in_ready), .data_out(b_out), .data_out_valid(b_out_valid),
        .data_out_ready(b_out_ready), .beat_count(b_bc));

    int_adder_tree_stream #(.NUM_IN_WORDS(8), .IN_WIDTH(8), .SIGNED(1), .ACC_BEATS(4)) dut_c (
        .clk(clk), .rst(rst), .data_in(c_data), .data_in_valid(c_in_valid),
        .data_in_ready(c_in_ready), .data_out(c_out), .data_out_valid(c_out_valid),
        .data_out_ready(c_out_ready), .beat_count(c_bc));

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int a_q[$];
    int b_q[$];
    int c_q[$];
    int c_acc_m   = 0;
    int c_beats_m = 0;
    int a_nout    = 0;
    int c_nout    = 0;

    // Values sampled just before the coming edge
    logic        a_accepted, b_accepted, c_accepted;
    logic        a_s_in_ready, a_s_out_valid;
    logic [10:0] a_s_out;

    function automatic int sum_s8(input logic [63:0] v);
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'($signed(v[i*8 +: 8]));
        return s;
    endfunction

    function automatic int sum_u5(input logic [39:0] v);
        int s = 0;
        for (int i = 0; i < 5; i++) s += int'(v[i*8 +: 8]);
        return s;
    endfunction

    // Builds a random signed 8-word vector that sums to target.
    function automatic logic [63:0] make_vec(input int target);
        logic [63:0] v;
        int s = 0;
        int w;
        for (int i = 0; i < 7; i++) begin
            w = int'($urandom_range(20)) - 10;
            s += w;
            v[i*8 +: 8] = 8'(w);
        end
        v[56 +: 8] = 8'(target - s);
        return v;
    endfunction

    // One clock cycle. The task is entered at a negedge with inputs already
    // driven. It samples the handshakes 1 ns later, updates the model and
    // scoreboards, and returns at the next negedge.
    task automatic tick();
        int exp;
        #1;
        a_s_in_ready  = a_in_ready;
        a_s_out_valid = a_out_valid;
        a_s_out       = a_out;
        a_accepted    = a_in_valid && a_in_ready && !rst;
        b_accepted    = b_in_valid && b_in_ready && !rst;
        c_accepted    = c_in_valid && c_in_ready && !rst;
        if (rst) begin
            a_q.delete();
            b_q.delete();
            c_q.delete();
            c_acc_m   = 0;
            c_beats_m = 0;
        end else begin
            if (a_out_valid && a_out_ready) begin
                checks++;
                a_nout++;
                if (a_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_a unexpected output got %0d required none", int'($signed(a_out)));
                end else begin
                    exp = a_q.pop_front();
                    if (int'($signed(a_out)) !== exp) begin
                        failures++;
                        $display("FAIL sb_a got %0d required %0d", int'($signed(a_out)), exp);
                    end
                end
            end
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (b_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_b unexpected output got %0d required none", int'(b_out));
                end else begin
                    exp = b_q.pop_front();
                    if (int'(b_out) !== exp) begin
                        failures++;
                        $display("FAIL sb_b got %0d required %0d", int'(b_out), exp);
                    end
                end
            end
            if (c_out_valid && c_out_ready) begin
                checks++;
                c_nout++;
                if (c_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_c unexpected output got %0d required none", int'($signed(c_out)));
                end else begin
                    exp = c_q.pop_front();
                    if (int'($signed(c_out)) !== exp) begin
                        failures++;
                        $display("FAIL sb_c got %0d required %0d", int'($signed(c_out)), exp);
                    end
                end
            end
            if (a_accepted) a_q.push_back(sum_s8(a_data));
            if (b_accepted) b_q.push_back(sum_u5(b_data));
            if (c_accepted) begin
                c_acc_m += sum_s8(c_data);
                c_beats_m++;
                if (c_beats_m == 4) begin
                    c_q.push_back(c_acc_m);
                    c_acc_m   = 0;
                    c_beats_m = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 6;
        if (a_out_valid !== 1'b0 || a_out !== 11'd0) begin
            failures++;
            $display("FAIL reset_a_out got valid=%0b data=%0d required valid=0 data=0", a_out_valid, a_out);
        end
        if (b_out_valid !== 1'b0 || b_out !== 11'd0) begin
            failures++;
            $display("FAIL reset_b_out got valid=%0b data=%0d required valid=0 data=0", b_out_valid, b_out);
        end
        if (c_out_valid !== 1'b0 || c_out !== 13'd0) begin
            failures++;
            $display("FAIL reset_c_out got valid=%0b data=%0d required valid=0 data=0", c_out_valid, c_out);
        end
        if (c_bc !== 3'd0 || a_bc !== 1'b0) begin
            failures++;
            $display("FAIL reset_beat_count got c=%0d a=%0d required 0", c_bc, a_bc);
        end
        if (a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_a_ready got %0b required 1", a_in_ready);
        end
        if (c_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_c_ready got %0b required 1", c_in_ready);
        end
    endtask

    task automatic test_basic_signed();
        logic [63:0] vecs [2];
        int          exps [2];
        for (int i = 0; i < 8; i++) vecs[0][i*8 +: 8] = 8'(i + 1);
        vecs[1] = {8{8'h80}};
        exps[0] = 36;
        exps[1] = -1024;
        for (int v = 0; v < 2; v++) begin
            a_data     = vecs[v];
            a_in_valid = 1'b1;
            tick();
            a_in_valid = 1'b0;
            for (int j = 1; j <= 3; j++) begin
                tick();
                checks++;
                if (a_out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_early_valid vec=%0d cycle=%0d got 1 required 0", v, j);
                end
            end
            tick();
            checks++;
            if (a_out_valid !== 1'b1 || int'($signed(a_out)) !== exps[v]) begin
                failures++;
                $display("FAIL basic_latency4 vec=%0d got valid=%0b data=%0d required valid=1 data=%0d",
                         v, a_out_valid, int'($signed(a_out)), exps[v]);
            end
        end
        for (int n = 0; n < 20 && a_q.size() != 0; n++) tick();
        checks++;
        if (a_q.size() != 0) begin
            failures++;
            $display("FAIL basic_drain got pending=%0d required 0", a_q.size());
        end
    endtask

    task automatic test_odd_unsigned();
        b_data     = {5{8'hFF}};
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            checks++;
            if (b_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL odd_early_valid cycle=%0d got 1 required 0", j);
            end
        end
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || int'(b_out) !== 1275) begin
            failures++;
            $display("FAIL odd_all255 got valid=%0b data=%0d required valid=1 data=1275", b_out_valid, b_out);
        end
        // Random unsigned vectors, back to back
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < 5; i++) b_data[i*8 +: 8] = 8'($urandom_range(255));
            b_in_valid = 1'b1;
            tick();
        end
        b_in_valid = 1'b0;
        for (int n = 0; n < 20 && b_q.size() != 0; n++) tick();
        checks++;
        if (b_q.size() != 0) begin
            failures++;
            $display("FAIL odd_drain got pending=%0d required 0", b_q.size());
        end
    endtask

    task automatic test_accumulation();
        int bcl [10];
        int ovl [10];
        int exp_bc [6] = '{0, 1, 2, 2, 3, 0};
        int out_val = 0;
        int nout0 = c_nout;
        for (int k = 0; k < 10; k++) begin
            case (k)
                0: begin c_in_valid = 1'b1; c_data = make_vec(10); end
                1: begin c_in_valid = 1'b1; c_data = make_vec(20); end
                3: begin c_in_valid = 1'b1; c_data = make_vec(30); end
                4: begin c_in_valid = 1'b1; c_data = make_vec(40); end
                default: c_in_valid = 1'b0;
            endcase
            tick();
            bcl[k] = int'(c_bc);
            ovl[k] = int'(c_out_valid);
            if (k == 8) out_val = int'($signed(c_out));
        end
        for (int k = 3; k <= 8; k++) begin
            checks++;
            if (bcl[k] !== exp_bc[k-3]) begin
                failures++;
                $display("FAIL acc_beat_count step=%0d got %0d required %0d", k - 3, bcl[k], exp_bc[k-3]);
            end
        end
        for (int k = 3; k <= 8; k++) begin
            checks++;
            if (ovl[k] !== ((k == 8) ? 1 : 0)) begin
                failures++;
                $display("FAIL acc_out_valid step=%0d got %0d required %0d", k - 3, ovl[k], (k == 8) ? 1 : 0);
            end
        end
        checks++;
        if (out_val !== 100) begin
            failures++;
            $display("FAIL acc_value got %0d required 100", out_val);
        end
        for (int n = 0; n < 6; n++) tick();
        checks++;
        if (c_nout - nout0 !== 1) begin
            failures++;
            $display("FAIL acc_output_count got %0d required 1", c_nout - nout0);
        end
    endtask

    task automatic test_backpressure();
        int          k = 1;
        int          cur_k = 0;
        logic [10:0] held = '0;
        int          nout0 = a_nout;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (k <= 20) begin
                if (k != cur_k) begin
                    a_data = make_vec(k);
                    cur_k  = k;
                end
                a_in_valid = 1'b1;
            end else begin
                a_in_valid = 1'b0;
            end
            a_out_ready = !(cyc >= 10 && cyc < 15);
            tick();
            if (a_accepted) k++;
            if (cyc >= 10 && cyc < 15) begin
                checks += 2;
                if (a_s_in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready cycle=%0d got %0b required 0", cyc, a_s_in_ready);
                end
                if (a_s_out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_out_valid cycle=%0d got %0b required 1", cyc, a_s_out_valid);
                end
                if (cyc == 10) begin
                    held = a_s_out;
                end else begin
                    checks++;
                    if (a_s_out !== held) begin
                        failures++;
                        $display("FAIL bp_frozen cycle=%0d got %0d required %0d", cyc, a_s_out, held);
                    end
                end
            end
        end
        a_out_ready = 1'b1;
        checks += 2;
        if (k !== 21) begin
            failures++;
            $display("FAIL bp_all_accepted got %0d required 21", k - 1);
        end
        if (a_q.size() != 0 || a_nout - nout0 !== 20) begin
            failures++;
            $display("FAIL bp_outputs got count=%0d pending=%0d required count=20 pending=0",
                     a_nout - nout0, a_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int nout0 = a_nout;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            a_data     = {$urandom, $urandom};
            a_in_valid = 1'b1;
            tick();
            checks++;
            if (a_accepted !== 1'b1) begin
                failures++;
                $display("FAIL b2b_accept cycle=%0d got 0 required 1", cyc);
            end
            if (cyc >= 5) begin
                checks++;
                if (a_s_out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_out_valid cycle=%0d got 0 required 1", cyc);
                end
            end
        end
        a_in_valid = 1'b0;
        for (int n = 0; n < 20 && a_q.size() != 0; n++) tick();
        tick();
        checks++;
        if (a_nout - nout0 !== 30 || a_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count got %0d pending=%0d required 30 pending=0", a_nout - nout0, a_q.size());
        end
    endtask

    task automatic test_reset_mid_acc();
        int nout0;
        c_in_valid = 1'b1;
        c_data     = make_vec(int'($urandom_range(40)));
        tick();
        c_data     = make_vec(int'($urandom_range(40)));
        tick();
        c_in_valid = 1'b0;
        rst        = 1'b1;
        tick();
        checks++;
        if (c_out !== 13'd0 || c_out_valid !== 1'b0 || c_bc !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_state got data=%0d valid=%0b bc=%0d required 0 0 0", c_out, c_out_valid, c_bc);
        end
        tick();
        checks++;
        if (c_out !== 13'd0 || c_out_valid !== 1'b0 || c_bc !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_hold got data=%0d valid=%0b bc=%0d required 0 0 0", c_out, c_out_valid, c_bc);
        end
        rst = 1'b0;
        checks++;
        if (c_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ready got %0b required 1", c_in_ready);
        end
        nout0 = c_nout;
        for (int b = 0; b < 4; b++) begin
            c_in_valid = 1'b1;
            c_data     = make_vec(5);
            tick();
        end
        c_in_valid = 1'b0;
        for (int n = 0; n < 20 && c_q.size() != 0; n++) tick();
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (c_nout - nout0 !== 1 || c_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_outputs got %0d pending=%0d required 1 pending=0", c_nout - nout0, c_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        a_data      = '0;
        b_data      = '0;
        c_data      = '0;
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        c_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        c_out_ready = 1'b1;
        @(negedge clk);

        test_reset();
        test_basic_signed();
        test_odd_unsigned();
        test_accumulation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_acc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
